// File: rtl/score_display_ctrl_if.sv
// Bundle between game logic and score_display_ctrl: two score sources, select, digit/enable outputs.
// Latency: none (pure signal bundle).
// Backpressure: none; inputs are levels, outputs are held between commits.
// Ports: value_a_i/value_b_i (14b scores), sel_b_i (source select),
//        digit0_o..digit3_o (BCD), digit0_en_o..digit3_en_o, busy_o, sat_o.
interface score_display_ctrl_if;
    logic [13:0] value_a_i;
    logic [13:0] value_b_i;
    logic        sel_b_i;
    logic [3:0]  digit0_o;
    logic [3:0]  digit1_o;
    logic [3:0]  digit2_o;
    logic [3:0]  digit3_o;
    logic        digit0_en_o;
    logic        digit1_en_o;
    logic        digit2_en_o;
    logic        digit3_en_o;
    logic        busy_o;
    logic        sat_o;

    // Game-logic side: drives the scores, observes the display state.
    modport master (
        output value_a_i, value_b_i, sel_b_i,
        input  digit0_o, digit1_o, digit2_o, digit3_o,
        input  digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        input  busy_o, sat_o
    );

    // Controller side.
    modport slave (
        input  value_a_i, value_b_i, sel_b_i,
        output digit0_o, digit1_o, digit2_o, digit3_o,
        output digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        output busy_o, sat_o
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Converts the selected 14-bit score to 4 blanked BCD digits with a serial double-dabble engine.
// Latency: 16 cycles from change detection in IDLE to visible digits (14 shift + 1 commit + 1 register).
// Backpressure: none; input changes while busy are ignored, the final value is picked up in the next IDLE.
// Ports: clk_i, rst_i (sync, active high), bus (score_display_ctrl_if.slave).
module score_display_ctrl #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    score_display_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [13:0] r_last_v;
    logic        r_last_sel;
    logic [3:0]  r_cnt;
    logic [29:0] r_sr;          // [29:14] BCD thousands..ones, [13:0] binary
    logic        r_sat_pend;    // clamp flag of the conversion in flight

    logic [3:0]  r_d0, r_d1, r_d2, r_d3;
    logic        r_en1, r_en2, r_en3;
    logic        r_sat;

    logic [13:0] w_v;
    logic        w_over;
    logic [13:0] w_clamped;
    logic        w_start;
    logic [29:0] w_sr_adj;
    logic        w_busy;
    logic        w_en1, w_en2, w_en3;

    assign w_v       = bus.sel_b_i ? bus.value_b_i : bus.value_a_i;
    assign w_over    = (w_v > 14'd9999);
    assign w_clamped = w_over ? 14'd9999 : w_v;
    // Compare against the unclamped value so e.g. 12000 -> 13000 is still seen as a change.
    assign w_start   = (r_state == S_IDLE) &&
                       ((w_v != r_last_v) || (bus.sel_b_i != r_last_sel));

    // Add-3 correction on every BCD nibble >= 5 before the shift.
    always_comb begin
        w_sr_adj = r_sr;
        for (int i = 0; i < 4; i++) begin
            if (r_sr[14 + 4*i +: 4] >= 4'd5)
                w_sr_adj[14 + 4*i +: 4] = r_sr[14 + 4*i +: 4] + 4'd3;
        end
    end

    // Enables derived from the finished BCD nibbles, used at commit.
    always_comb begin
        w_en3 = 1'b1;
        w_en2 = 1'b1;
        w_en1 = 1'b1;
        if (BLANK_LEADING) begin
            w_en3 = |r_sr[29:26];
            w_en2 = |r_sr[29:22];
            w_en1 = |r_sr[29:18];
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_cnt == 4'd13) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_v   <= '0;
            r_last_sel <= 1'b0;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_sat_pend <= 1'b0;
            r_d0       <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
            r_en1      <= 1'b0;
            r_en2      <= 1'b0;
            r_en3      <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_last_v   <= w_v;
                        r_last_sel <= bus.sel_b_i;
                        r_sr       <= {16'b0, w_clamped};
                        r_cnt      <= '0;
                        r_sat_pend <= w_over;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_sr_adj << 1;
                    r_cnt <= r_cnt + 4'd1;
                end
                S_COMMIT: begin
                    r_d3  <= r_sr[29:26];
                    r_d2  <= r_sr[25:22];
                    r_d1  <= r_sr[21:18];
                    r_d0  <= r_sr[17:14];
                    r_en3 <= w_en3;
                    r_en2 <= w_en2;
                    r_en1 <= w_en1;
                    r_sat <= r_sat_pend;
                end
                default: ;
            endcase
        end
    end

    assign bus.digit0_o    = r_d0;
    assign bus.digit1_o    = r_d1;
    assign bus.digit2_o    = r_d2;
    assign bus.digit3_o    = r_d3;
    assign bus.digit0_en_o = 1'b1;
    assign bus.digit1_en_o = r_en1;
    assign bus.digit2_en_o = r_en2;
    assign bus.digit3_en_o = r_en3;
    assign bus.busy_o      = w_busy;
    assign bus.sat_o       = r_sat;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomised + directed bench for score_display_ctrl, two instances (blanking on / off).
// Latency: a behavioural countdown model predicts busy and the committed display every cycle.
// Backpressure: n/a; stimulus changes inputs freely, including while busy.
module tb_score_display_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] a_val;
    logic [13:0] b_val;
    logic        sel;
    bit          chk_en;

    int n_vec;
    int n_err;

    score_display_ctrl_if if_b ();
    score_display_ctrl_if if_n ();

    assign if_b.value_a_i = a_val;
    assign if_b.value_b_i = b_val;
    assign if_b.sel_b_i   = sel;
    assign if_n.value_a_i = a_val;
    assign if_n.value_b_i = b_val;
    assign if_n.sel_b_i   = sel;

    score_display_ctrl #(.BLANK_LEADING(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
    score_display_ctrl #(.BLANK_LEADING(1'b0)) dut_n (.clk_i(clk), .rst_i(rst), .bus(if_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_rem: cycles left until the pending result is visible (0 = idle).
    int m_rem;
    int m_last_v;
    bit m_last_sel;
    int m_pend;
    bit m_pend_sat;
    int m_dv;
    bit m_sat;
    bit m_committed;

    initial begin
        m_rem = 0; m_last_v = 0; m_last_sel = 0; m_pend = 0;
        m_pend_sat = 0; m_dv = 0; m_sat = 0; m_committed = 0;
    end

    always @(posedge clk) begin
        int v;
        v = sel ? int'(b_val) : int'(a_val);
        if (rst) begin
            m_rem = 0; m_last_v = 0; m_last_sel = 0;
            m_dv = 0; m_sat = 0; m_committed = 0;
        end else if (m_rem == 0) begin
            if (v != m_last_v || sel != m_last_sel) begin
                m_last_v   = v;
                m_last_sel = sel;
                m_pend     = (v > 9999) ? 9999 : v;
                m_pend_sat = (v > 9999);
                m_rem      = 15;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_dv        = m_pend;
                m_sat       = m_pend_sat;
                m_committed = 1;
            end
        end
    end

    // {busy, sat, en3..en0, d3, d2, d1, d0}
    function automatic logic [21:0] model_vec(bit blank);
        logic [3:0] en;
        logic [15:0] d;
        d = {4'((m_dv / 1000) % 10), 4'((m_dv / 100) % 10),
             4'((m_dv / 10) % 10), 4'(m_dv % 10)};
        en = {m_dv >= 1000, m_dv >= 100, m_dv >= 10, 1'b1};
        if (!blank && m_committed) en = 4'b1111;
        return {m_rem != 0, m_sat, en, d};
    endfunction

    function automatic logic [21:0] vec_b();
        return {if_b.busy_o, if_b.sat_o,
                if_b.digit3_en_o, if_b.digit2_en_o, if_b.digit1_en_o, if_b.digit0_en_o,
                if_b.digit3_o, if_b.digit2_o, if_b.digit1_o, if_b.digit0_o};
    endfunction

    function automatic logic [21:0] vec_n();
        return {if_n.busy_o, if_n.sat_o,
                if_n.digit3_en_o, if_n.digit2_en_o, if_n.digit1_en_o, if_n.digit0_en_o,
                if_n.digit3_o, if_n.digit2_o, if_n.digit1_o, if_n.digit0_o};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_blank",   vec_b(), model_vec(1'b1));
            check("model_noblank", vec_n(), model_vec(1'b0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 14'($urandom_range(0, 20));
            1:       return 14'($urandom_range(0, 9999));
            2:       return 14'($urandom_range(9990, 16383));
            default: return 14'd9999;
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        rst = 1'b1; a_val = '0; b_val = '0; sel = 1'b0;

        step(1);
        chk_en = 1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_b", vec_b(), {1'b0, 1'b0, 4'b0001, 16'h0000});
        check("reset_n", vec_n(), {1'b0, 1'b0, 4'b0001, 16'h0000});
        step(5);
        check("idle_zero", vec_b(), {1'b0, 1'b0, 4'b0001, 16'h0000});

        // 0 -> 1234: busy for cycles 1..15, result at cycle 16
        a_val = 14'd1234;
        @(negedge clk);
        check("c0_busy", {21'b0, if_b.busy_o}, 22'd0);
        step(1);
        check("c1_busy", {21'b0, if_b.busy_o}, 22'd1);
        step(14);
        check("c15_busy", {21'b0, if_b.busy_o}, 22'd1);
        step(1);
        check("lit_1234", vec_b(), {1'b0, 1'b0, 4'b1111, 16'h1234});

        // blanking on/off
        a_val = 14'd7;
        step(16);
        check("lit_7_blank",   vec_b(), {1'b0, 1'b0, 4'b0001, 16'h0007});
        check("lit_7_noblank", vec_n(), {1'b0, 1'b0, 4'b1111, 16'h0007});

        // saturation then recovery
        a_val = 14'd12000;
        step(16);
        check("lit_sat", vec_b(), {1'b0, 1'b1, 4'b1111, 16'h9999});
        a_val = 14'd305;
        step(16);
        check("lit_305", vec_b(), {1'b0, 1'b0, 4'b0111, 16'h0305});

        // source switching with change while busy
        a_val = 14'd42; b_val = 14'd8765;
        step(16);
        check("lit_42", vec_b(), {1'b0, 1'b0, 4'b0011, 16'h0042});
        sel = 1'b1;
        step(3);
        b_val = 14'd100;
        step(13);
        check("lit_8765", vec_b(), {1'b0, 1'b0, 4'b1111, 16'h8765});
        step(16);
        check("lit_100", vec_b(), {1'b0, 1'b0, 4'b0111, 16'h0100});

        // select toggle with equal values still converts
        sel = 1'b0; a_val = 14'd100;
        step(1);
        check("toggle_busy", {21'b0, if_b.busy_o}, 22'd1);
        step(15);
        check("toggle_same", vec_b(), {1'b0, 1'b0, 4'b0111, 16'h0100});

        // reset mid-shift
        a_val = 14'd4321;
        step(7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_b", vec_b(), {1'b0, 1'b0, 4'b0001, 16'h0000});
        check("rst_mid_n", vec_n(), {1'b0, 1'b0, 4'b0001, 16'h0000});
        step(16);
        check("after_rst", vec_b(), {1'b0, 1'b0, 4'b1111, 16'h4321});

        // randomised phase, checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a_val = rand_val();
                3, 4:    b_val = rand_val();
                5, 6:    sel = ~sel;
                7: begin
                    rst = 1'b1;
                    step(1);
                    rst = 1'b0;
                end
                default: ;
            endcase
            step($urandom_range(0, 20));
        end
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
